// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 red/green LED matrix scan driver with frame-boundary swaps.
// Optional anti-ghost blanking at the start of each column: define LED_GHOST_BLANK_EN.
module led_matrix_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_col,
  input  logic [7:0]  wr_red,
  input  logic [7:0]  wr_green,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic [0:27] led
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);
  localparam logic [0:27]      LED_RST   = {24'hFFFFFF, 3'b000, 1'b1};

`ifdef LED_GHOST_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_col;
  logic             r_bank_sel;
  logic             r_swap_pend;

  logic [7:0] r_red   [2][8];
  logic [7:0] r_green [2][8];

  logic       w_pre_last;
  logic       w_boundary;
  logic       w_swap;
  logic [7:0] w_red_col;
  logic [7:0] w_green_col;
  logic [0:15] w_pix;

  assign w_pre_last = (r_pre == PRE_LAST);
  assign w_boundary = w_pre_last && (r_col == 3'd7);
  assign w_swap     = w_boundary && swap_req;

  // Scan counters and swap control; col wraps 7->0 on its own, so a swap needs no extra col logic
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pre       <= '0;
      r_col       <= '0;
      r_bank_sel  <= 1'b0;
      r_swap_pend <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      r_swap_pend <= w_swap;
      swap_ack    <= r_swap_pend;
      if (w_pre_last) begin
        r_pre <= '0;
        r_col <= r_col + 3'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
      end
    end
  end

  // Writes always land in the pre-edge back bank, even on a swap edge
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < 8; c++) begin
          r_red[b][c]   <= '0;
          r_green[b][c] <= '0;
        end
      end
    end else if (wr_en) begin
      r_red[~r_bank_sel][wr_col]   <= wr_red;
      r_green[~r_bank_sel][wr_col] <= wr_green;
    end
  end

  always_comb begin
    w_red_col   = r_red[r_bank_sel][r_col];
    w_green_col = r_green[r_bank_sel][r_col];
    w_pix       = {~w_red_col, ~w_green_col};
    if (BLANK_EN && (r_pre < BLANK_END)) begin
      w_pix = '1;
    end
  end

  // Output stage: one cycle behind the scan registers, aligned with swap_ack
  always_ff @(posedge CLK) begin
    if (reset) begin
      led <= LED_RST;
    end else begin
      led <= {w_pix, 8'hFF, r_col, 1'b1};
    end
  end

endmodule
